// File: rtl/seq_player.sv
// Simon sequence RAM plus playback timer: plays the first `level` stored symbols as
// one-hot LED blinks, then pulses done. Optional level-based speedup: SEQ_PLAYER_SPEEDUP_EN.
module seq_player #(
  parameter int NUM_LEDS     = 4,
  parameter int DEPTH        = 16,
  parameter int ON_CYCLES    = 25_000_000,
  parameter int OFF_CYCLES   = 12_500_000,
  parameter int SPEEDUP_STEP = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [$clog2(DEPTH)-1:0]    wr_addr,
  input  logic [$clog2(NUM_LEDS)-1:0] wr_data,
  input  logic                        start,
  input  logic [$clog2(DEPTH):0]      level,
  output logic [NUM_LEDS-1:0]         led_out,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(DEPTH)-1:0]    step
);

  localparam int AW     = $clog2(DEPTH);
  localparam int SW     = $clog2(NUM_LEDS);
  localparam int LW     = AW + 1;
  localparam int MAXCYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW     = $clog2(MAXCYC + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_ON   = 3'd2;
  localparam logic [2:0] S_OFF  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  generate
    if (NUM_LEDS < 2 || NUM_LEDS > 16)
      $error("seq_player: NUM_LEDS must be 2..16");
    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0)
      $error("seq_player: DEPTH must be a power of 2 in 2..256");
    if (ON_CYCLES < 1 || OFF_CYCLES < 1)
      $error("seq_player: ON_CYCLES and OFF_CYCLES must be >= 1");
    if (SPEEDUP_STEP < 1)
      $error("seq_player: SPEEDUP_STEP must be >= 1");
  endgenerate

  logic [2:0]          r_state;
  logic [TW-1:0]       r_timer;
  logic [AW-1:0]       r_step;
  logic [AW-1:0]       r_last;
  logic                r_busy;
  logic [TW-1:0]       r_on_load;
  logic [SW-1:0]       r_sym;
  logic [SW-1:0]       r_mem [DEPTH];

  logic [LW-1:0]       w_level_sat;
  logic [TW-1:0]       w_on_load;
  logic [31:0]         w_sym_ext;
  logic [NUM_LEDS-1:0] w_led;

  assign w_level_sat = (level > LW'(DEPTH)) ? LW'(DEPTH) : level;

`ifdef SEQ_PLAYER_SPEEDUP_EN
  // On-time halves every SPEEDUP_STEP levels, floored at one cycle.
  always_comb begin
    logic [31:0] v_on;
    v_on = 32'(ON_CYCLES) >> (32'(w_level_sat) / 32'(SPEEDUP_STEP));
    if (v_on == 32'd0) v_on = 32'd1;
    w_on_load = TW'(v_on - 32'd1);
  end
`else
  assign w_on_load = TW'(ON_CYCLES - 1);
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_step    <= '0;
      r_last    <= '0;
      r_busy    <= 1'b0;
      r_on_load <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (level == '0) begin
              r_state <= S_DONE;
            end else begin
              r_step    <= '0;
              r_last    <= AW'(w_level_sat - LW'(1));
              r_on_load <= w_on_load;
              r_state   <= S_READ;
            end
          end
        end
        S_READ: begin
          r_timer <= r_on_load;
          r_state <= S_ON;
        end
        S_ON: begin
          if (r_timer == '0) begin
            r_timer <= TW'(OFF_CYCLES - 1);
            r_state <= S_OFF;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_OFF: begin
          if (r_timer == '0) begin
            if (r_step == r_last) begin
              r_state <= S_DONE;
            end else begin
              r_step  <= r_step + AW'(1);
              r_state <= S_READ;
            end
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the RAM array is deliberately not reset; a reset port on a memory
  // prevents block-RAM inference and the stored sequence must survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && !r_busy) r_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 r_sym <= '0;
    else if (r_state == S_READ) r_sym <= r_mem[r_step];
  end

  assign w_sym_ext = 32'(r_sym);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_led = '0;
    if (r_state == S_ON && w_sym_ext < 32'(NUM_LEDS)) w_led[r_sym] = 1'b1;
  end

  assign led_out = w_led;
  assign busy    = r_busy;
  assign done    = (r_state == S_DONE);
  assign step    = r_step;

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player: per-cycle vector table for a 3-step playback,
// plus hand sequences for level 0, reset abort, level saturation and speedup.
module tb_seq_player;

  localparam int NL   = 4;
  localparam int DP   = 16;
  localparam int ONC  = 3;
  localparam int OFFC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [1:0] wr_data = '0;
  logic       start = 1'b0;
  logic [4:0] level = '0;
  logic [3:0] led_out;
  logic       busy;
  logic       done;
  logic [3:0] step;

  int n_tests = 0;
  int n_fail  = 0;

  seq_player #(
    .NUM_LEDS(NL), .DEPTH(DP), .ON_CYCLES(ONC), .OFF_CYCLES(OFFC), .SPEEDUP_STEP(4)
  ) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .level(level), .led_out(led_out), .busy(busy), .done(done), .step(step)
  );

`ifdef SEQ_PLAYER_SPEEDUP_EN
  logic       f_start = 1'b0;
  logic [3:0] f_led;
  logic       f_busy;
  logic       f_done;
  logic [3:0] f_step;

  seq_player #(
    .NUM_LEDS(NL), .DEPTH(DP), .ON_CYCLES(8), .OFF_CYCLES(OFFC), .SPEEDUP_STEP(4)
  ) u_fast (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(f_start), .level(level), .led_out(f_led), .busy(f_busy), .done(f_done), .step(f_step)
  );
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       wr;
    logic [3:0] led;
    logic       busy;
    logic       done;
    logic [3:0] step;
  } vec_t;

  vec_t vt[21];

  logic [3:0] rec_led [128];
  logic       rec_busy[128];
  logic       rec_done[128];
  logic [3:0] rec_step[128];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [1:0] d);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  // Index k holds the outputs during the k-th cycle after the start edge.
  task automatic run_play(input logic [4:0] lv, input int n);
    level = lv;
    for (int k = 0; k < n; k++) begin
      rec_led[k]  = led_out;
      rec_busy[k] = busy;
      rec_done[k] = done;
      rec_step[k] = step;
      start = (k == 0);
      tick();
    end
    start = 1'b0;
  endtask

  function automatic int exp_on(input int lv);
`ifdef SEQ_PLAYER_SPEEDUP_EN
    int t;
    t = ONC >> (lv / 4);
    return (t < 1) ? 1 : t;
`else
    return ONC + 0 * lv;
`endif
  endfunction

  function automatic vec_t mk(input logic s, input logic w, input logic [3:0] l,
                              input logic b, input logic d, input logic [3:0] st);
    vec_t v;
    v.start = s; v.wr = w; v.led = l; v.busy = b; v.done = d; v.step = st;
    return v;
  endfunction

  initial begin
    int first_done, n_done, max_step, n_lit;

    // RAM = {2,0,3}, level 3: READ,ON x3,OFF x2 per step, DONE at cycle 19.
    vt[0]  = mk(1, 0, 4'b0000, 0, 0, 0);
    vt[1]  = mk(0, 0, 4'b0000, 1, 0, 0);
    vt[2]  = mk(0, 0, 4'b0100, 1, 0, 0);
    vt[3]  = mk(0, 0, 4'b0100, 1, 0, 0);
    vt[4]  = mk(0, 0, 4'b0100, 1, 0, 0);
    vt[5]  = mk(0, 0, 4'b0000, 1, 0, 0);
    vt[6]  = mk(0, 0, 4'b0000, 1, 0, 0);
    vt[7]  = mk(0, 0, 4'b0000, 1, 0, 1);
    vt[8]  = mk(0, 0, 4'b0001, 1, 0, 1);
    vt[9]  = mk(1, 1, 4'b0001, 1, 0, 1);
    vt[10] = mk(0, 0, 4'b0001, 1, 0, 1);
    vt[11] = mk(0, 0, 4'b0000, 1, 0, 1);
    vt[12] = mk(0, 0, 4'b0000, 1, 0, 1);
    vt[13] = mk(0, 0, 4'b0000, 1, 0, 2);
    vt[14] = mk(0, 0, 4'b1000, 1, 0, 2);
    vt[15] = mk(0, 0, 4'b1000, 1, 0, 2);
    vt[16] = mk(0, 0, 4'b1000, 1, 0, 2);
    vt[17] = mk(0, 0, 4'b0000, 1, 0, 2);
    vt[18] = mk(0, 0, 4'b0000, 1, 0, 2);
    vt[19] = mk(0, 0, 4'b0000, 1, 1, 2);
    vt[20] = mk(0, 0, 4'b0000, 0, 0, 2);

    #1;
    check("reset_led",  32'(led_out), 32'h0);
    check("reset_busy", 32'(busy),    32'h0);
    check("reset_done", 32'(done),    32'h0);
    check("reset_step", 32'(step),    32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    wr(4'd0, 2'd2);
    wr(4'd1, 2'd0);
    wr(4'd2, 2'd3);

    // Table run; cycle 9 also attempts a RAM write and a second start.
    level = 5'd3;
    for (int i = 0; i < 21; i++) begin
      check($sformatf("v%0d_led", i),  32'(led_out), 32'(vt[i].led));
      check($sformatf("v%0d_busy", i), 32'(busy),    32'(vt[i].busy));
      check($sformatf("v%0d_done", i), 32'(done),    32'(vt[i].done));
      check($sformatf("v%0d_step", i), 32'(step),    32'(vt[i].step));
      start   = vt[i].start;
      wr_en   = vt[i].wr;
      wr_addr = 4'd1;
      wr_data = 2'd1;
      tick();
    end
    start = 1'b0;
    wr_en = 1'b0;

    // level 0: straight to DONE, no LED.
    run_play(5'd0, 4);
    check("lvl0_done1", 32'(rec_done[1]), 32'h1);
    check("lvl0_busy1", 32'(rec_busy[1]), 32'h1);
    check("lvl0_done2", 32'(rec_done[2]), 32'h0);
    check("lvl0_busy2", 32'(rec_busy[2]), 32'h0);
    n_lit = 0;
    for (int k = 0; k < 4; k++) if (rec_led[k] != 4'b0) n_lit++;
    check("lvl0_no_led", 32'(n_lit), 32'h0);

    // Reset during ON of step 1 aborts with no done pulse.
    level = 5'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check("rst_pre_led",  32'(led_out), 32'h1);
    check("rst_pre_step", 32'(step),    32'h1);
    reset = 1'b0;
    #1;
    check("rst_led",  32'(led_out), 32'h0);
    check("rst_busy", 32'(busy),    32'h0);
    check("rst_done", 32'(done),    32'h0);
    check("rst_step", 32'(step),    32'h0);
    tick();
    tick();
    reset = 1'b1;
    n_done = 0;
    for (int k = 0; k < 6; k++) begin
      if (done || busy) n_done++;
      tick();
    end
    check("rst_no_done", 32'(n_done), 32'h0);

    // Replay from step 0; step 1 still shows symbol 0, proving the busy write was dropped.
    run_play(5'd2, 16);
    check("replay_led2",   32'(rec_led[2]),   32'h4);
    check("replay_step2",  32'(rec_step[2]),  32'h0);
    check("replay_led8",   32'(rec_led[8]),   32'h1);
    check("replay_step8",  32'(rec_step[8]),  32'h1);
    check("replay_done12", 32'(rec_done[12]), 32'h0);
    check("replay_done13", 32'(rec_done[13]), 32'h1);

    // level 20 saturates to DEPTH.
    run_play(5'd20, 110);
    first_done = -1;
    n_done = 0;
    max_step = 0;
    for (int k = 0; k < 110; k++) begin
      if (rec_done[k]) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      if (int'(rec_step[k]) > max_step) max_step = int'(rec_step[k]);
    end
    check("sat_done_cycle", 32'(first_done), 32'(DP * (1 + exp_on(DP) + OFFC) + 1));
    check("sat_done_count", 32'(n_done), 32'h1);
    check("sat_max_step",   32'(max_step), 32'd15);
    check("sat_final_step", 32'(step), 32'd15);

`ifdef SEQ_PLAYER_SPEEDUP_EN
    // ON_CYCLES=8, level 8: on-time 8>>2 = 2; done at 8*(1+2+2)+1 = 41.
    level = 5'd8;
    f_start = 1'b1;
    tick();
    f_start = 1'b0;
    n_lit = 0;
    first_done = -1;
    for (int k = 1; k < 60; k++) begin
      if (k <= 5 && f_led != 4'b0) n_lit++;
      if (f_done && first_done < 0) first_done = k;
      tick();
    end
    check("fast_on_cycles", 32'(n_lit), 32'd2);
    check("fast_done_cycle", 32'(first_done), 32'd41);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
